// File: rtl/mux_arb_nt1_nb_if.sv
// Handshake bundle for mux_arb_nt1_nb: CH producer channels in, one consumer out.
// slave = the mux itself, master = the producers/consumer surrounding it.
interface mux_arb_nt1_nb_if #(
   parameter int unsigned N  = 8,
   parameter int unsigned CH = 5
);
   localparam int unsigned SW = $clog2(CH);

   logic [CH*N-1:0] d_in;
   logic [CH-1:0]   valid_in;
   logic [CH-1:0]   ready_out;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [N-1:0]    d_out;
   logic            valid_out;
   logic            ready_in;
   logic [SW-1:0]   sel_out;

   modport slave (
      input  d_in, valid_in, mode, sel, ready_in,
      output ready_out, d_out, valid_out, sel_out
   );

   modport master (
      output d_in, valid_in, mode, sel, ready_in,
      input  ready_out, d_out, valid_out, sel_out
   );
endinterface

// File: rtl/mux_arb_nt1_nb.sv
// Registered CH:1 mux with valid/ready on every channel; fixed (sel) or
// round-robin arbitration chosen by mode.
// Optional macro MUX_ARB_XFER_CNT_EN adds a saturating 16-bit xfer_cnt output
// counting completed output transfers.
module mux_arb_nt1_nb #(
   parameter int unsigned N  = 8,
   parameter int unsigned CH = 5
) (
   input logic             clk,
   input logic             rst_n,
   mux_arb_nt1_nb_if.slave bus
`ifdef MUX_ARB_XFER_CNT_EN
   ,
   output logic [15:0]     xfer_cnt
`endif
);
   localparam int unsigned SW = $clog2(CH);
   localparam int unsigned IW = SW + 1;

   logic [N-1:0]  ch_data [CH];
   logic [SW-1:0] cand;
   logic          cand_ok;
   logic [IW-1:0] idx;
   logic          ld;
   logic          take;
   logic [CH-1:0] ready_c;
   logic [SW-1:0] ptr;
   logic [SW-1:0] ptr_nxt;
   logic [N-1:0]  d_q;
   logic [SW-1:0] sel_q;
   logic          valid_q;

   // Unflatten the channel data bus
   for (genvar i = 0; i < CH; i++) begin : g_split
      assign ch_data[i] = bus.d_in[i*N +: N];
   end

   // Candidate selection: sel in fixed mode, first valid at/after ptr in round-robin
   always_comb begin
      cand    = '0;
      cand_ok = 1'b0;
      idx     = '0;
      if (!bus.mode) begin
         if (IW'(bus.sel) < IW'(CH)) begin
            cand    = bus.sel;
            cand_ok = bus.valid_in[bus.sel];
         end
      end else begin
         for (int unsigned k = 0; k < CH; k++) begin
            idx = IW'(ptr) + IW'(k);
            if (idx >= IW'(CH)) idx = idx - IW'(CH);
            if (!cand_ok && bus.valid_in[SW'(idx)]) begin
               cand    = SW'(idx);
               cand_ok = 1'b1;
            end
         end
      end
   end

   // Load when the output register is empty or being drained this cycle
   assign ld      = !valid_q | bus.ready_in;
   assign take    = ld & cand_ok;
   assign ptr_nxt = (32'(cand) == CH - 1) ? '0 : cand + SW'(1);

   // One-hot accept to the winning channel, forced low during reset
   always_comb begin
      ready_c = '0;
      if (rst_n && take) ready_c[cand] = 1'b1;
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q     <= '0;
         sel_q   <= '0;
         valid_q <= 1'b0;
         ptr     <= '0;
      end else if (take) begin
         d_q     <= ch_data[cand];
         sel_q   <= cand;
         valid_q <= 1'b1;
         if (bus.mode) ptr <= ptr_nxt;
      end else if (bus.ready_in) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.ready_out = ready_c;
   assign bus.d_out     = d_q;
   assign bus.sel_out   = sel_q;
   assign bus.valid_out = valid_q;

`ifdef MUX_ARB_XFER_CNT_EN
   // Saturating count of words handed to the consumer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (valid_q && bus.ready_in && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_mux_arb_nt1_nb.sv
// Randomised bench for mux_arb_nt1_nb against a cycle-level reference model.
// Build with MUX_ARB_XFER_CNT_EN defined to also exercise xfer_cnt.
module tb_mux_arb_nt1_nb;
   localparam int unsigned N  = 8;
   localparam int unsigned CH = 5;
   localparam int unsigned SW = $clog2(CH);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_arb_nt1_nb_if #(.N(N), .CH(CH)) bus ();

`ifdef MUX_ARB_XFER_CNT_EN
   logic [15:0] xfer_cnt;
`endif

   mux_arb_nt1_nb #(.N(N), .CH(CH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus)
`ifdef MUX_ARB_XFER_CNT_EN
      ,
      .xfer_cnt (xfer_cnt)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit           m_valid;
   logic [N-1:0] m_data;
   int           m_sel;
   int           m_ptr;
   int           m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // Winning channel or -1, straight from the arbitration rules
   function automatic int pick(input logic md, input int s, input logic [CH-1:0] v, input int p);
      if (!md) begin
         if (s < CH && v[s]) return s;
         return -1;
      end
      for (int k = 0; k < CH; k++)
         if (v[(p + k) % CH]) return (p + k) % CH;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   task automatic check_outputs();
      check("valid_out", 32'(bus.valid_out), 32'(m_valid));
      check("d_out",     32'(bus.d_out),     32'(m_data));
      check("sel_out",   32'(bus.sel_out),   32'(m_sel));
`ifdef MUX_ARB_XFER_CNT_EN
      check("xfer_cnt",  32'(xfer_cnt),      32'(m_cnt));
`endif
   endtask

   // One clock: apply inputs at negedge, check accept, advance model, check outputs
   task automatic step(input logic md, input logic [SW-1:0] s, input logic [CH-1:0] v,
                       input logic [CH*N-1:0] din, input logic rdy);
      int w;
      bit ld;
      logic [CH-1:0] exp_ro;
      bus.mode     = md;
      bus.sel      = s;
      bus.valid_in = v;
      bus.d_in     = din;
      bus.ready_in = rdy;
      #1;
      ld = !m_valid || rdy;
      w  = pick(md, int'(s), v, m_ptr);
      exp_ro = '0;
      if (ld && w >= 0) exp_ro[w] = 1'b1;
      check("ready_out", 32'(bus.ready_out), 32'(exp_ro));
      @(posedge clk);
      if (m_valid && rdy && m_cnt < 16'hFFFF) m_cnt++;
      if (ld && w >= 0) begin
         m_valid = 1;
         m_data  = din[w*N +: N];
         m_sel   = w;
         if (md) m_ptr = (w + 1) % CH;
      end else if (rdy) begin
         m_valid = 0;
      end
      @(negedge clk);
      check_outputs();
   endtask

   function automatic logic [CH*N-1:0] rand_din();
      logic [CH*N-1:0] d;
      for (int i = 0; i < CH; i++) d[i*N +: N] = N'($urandom);
      return d;
   endfunction

   // Asynchronous reset pulse starting between edges
   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check("rst valid_out", 32'(bus.valid_out), 32'd0);
      check("rst d_out",     32'(bus.d_out),     32'd0);
      check("rst sel_out",   32'(bus.sel_out),   32'd0);
      check("rst ready_out", 32'(bus.ready_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [CH*N-1:0] din;
      logic [N-1:0]    held;
      int              rr_seq [6];
      int              exp_seq [6];
      exp_seq = '{1, 2, 4, 1, 2, 4};

      bus.mode = 0; bus.sel = '0; bus.valid_in = '1; bus.d_in = '0; bus.ready_in = 1'b1;
      model_reset();
      @(negedge clk);
      pulse_reset();

      // Fixed mode, sel=3
      din = rand_din();
      din[3*N +: N] = 8'hA5;
      step(1'b0, SW'(3), 5'b11111, din, 1'b1);
      check("fixed d_out",   32'(bus.d_out),   32'hA5);
      check("fixed sel_out", 32'(bus.sel_out), 32'd3);

      // Drain, then out-of-range select for 10 cycles
      step(1'b0, SW'(0), 5'b00000, rand_din(), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b0, SW'(6), 5'b11111, rand_din(), 1'b1);
      check("oor valid_out", 32'(bus.valid_out), 32'd0);

      // Round-robin fairness over channels 1,2,4
      for (int i = 0; i < 6; i++) begin
         step(1'b1, SW'(0), 5'b10110, rand_din(), 1'b1);
         rr_seq[i] = int'(bus.sel_out);
      end
      for (int i = 0; i < 6; i++) check("rr seq", 32'(rr_seq[i]), 32'(exp_seq[i]));

      // Backpressure: 3 stalled cycles, then back-to-back load
      step(1'b1, SW'(0), 5'b11111, rand_din(), 1'b1);
      held = bus.d_out;
      for (int i = 0; i < 3; i++) step(1'b1, SW'(0), 5'b11111, rand_din(), 1'b0);
      check("stall d_out", 32'(bus.d_out), 32'(held));
      step(1'b1, SW'(0), 5'b11111, rand_din(), 1'b1);
      check("no bubble", 32'(bus.valid_out), 32'd1);

      // Reset mid-stall with a held word
      step(1'b1, SW'(0), 5'b11111, rand_din(), 1'b0);
      pulse_reset();

      // Random traffic, both modes, including out-of-range selects
      for (int i = 0; i < 1500; i++)
         step(1'($urandom), SW'($urandom_range(0, 7)), CH'($urandom), rand_din(),
              1'($urandom_range(0, 3) != 0));

`ifdef MUX_ARB_XFER_CNT_EN
      // 20 output transfers from a fresh reset
      @(negedge clk);
      pulse_reset();
      for (int i = 0; i < 21; i++) step(1'b1, SW'(0), 5'b11111, rand_din(), 1'b1);
      check("cnt 20", 32'(xfer_cnt), 32'd20);
      // Run far past 65535 transfers and confirm saturation
      for (int i = 0; i < 65600; i++) @(negedge clk);
      check("cnt sat", 32'(xfer_cnt), 32'hFFFF);
      @(negedge clk);
      check("cnt hold", 32'(xfer_cnt), 32'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
